dispatch_ctrl: RTL

DISPATCH_CTRL -- requirements
Module: dispatch_ctrl

---
 rtl/dispatch_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: in-order dispatch of a rename bundle into the INT/MEM/FP
// issue queues under per-queue credit flow control. A bundle can drain over
// several cycles; done_q remembers which slots have already been written.
module dispatch_ctrl #(
    parameter int DISPATCH_WIDTH = 4,
    parameter int IQ_INT_SIZE    = 16,
    parameter int IQ_MEM_SIZE    = 16,
    parameter int IQ_FP_SIZE     = 16
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  flush,
    input  logic                                  in_valid,
    input  logic [DISPATCH_WIDTH-1:0]             slot_valid,
    input  logic [2*DISPATCH_WIDTH-1:0]           slot_type,
    input  logic [$clog2(DISPATCH_WIDTH+1)-1:0]   int_free,
    input  logic [$clog2(DISPATCH_WIDTH+1)-1:0]   mem_free,
    input  logic [$clog2(DISPATCH_WIDTH+1)-1:0]   fp_free,
    output logic [DISPATCH_WIDTH-1:0]             disp_mask,
    output logic                                  in_ready,
    output logic                                  credit_err,
    output logic [31:0]                           stall_cycles
);

    localparam int CIW = $clog2(IQ_INT_SIZE + 1);
    localparam int CMW = $clog2(IQ_MEM_SIZE + 1);
    localparam int CFW = $clog2(IQ_FP_SIZE + 1);

    typedef enum logic [1:0] {
        T_INT  = 2'd0,
        T_MEM  = 2'd1,
        T_FP   = 2'd2,
        T_NONE = 2'd3
    } uop_type_e;

    logic [CIW-1:0]            cnt_int_q, cnt_int_d;
    logic [CMW-1:0]            cnt_mem_q, cnt_mem_d;
    logic [CFW-1:0]            cnt_fp_q,  cnt_fp_d;
    logic [DISPATCH_WIDTH-1:0] done_q,    done_d;
    logic                      err_q,     err_d;
    logic [31:0]               stall_q,   stall_d;

    int unsigned n_int, n_mem, n_fp;
    logic        blocked;
    int          nx_int, nx_mem, nx_fp;

    function automatic int sat(input int v, input int hi);
        if (v > hi)     return hi;
        else if (v < 0) return 0;
        else            return v;
    endfunction

    // Walk slots oldest first; the first pending slot without credit blocks
    // itself and every younger slot, which keeps dispatch strictly in order.
    always_comb begin
        disp_mask = '0;
        blocked   = 1'b0;
        n_int     = 0;
        n_mem     = 0;
        n_fp      = 0;
        for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
            if (in_valid && slot_valid[i] && !done_q[i] && !blocked) begin
                case (uop_type_e'(slot_type[2*i +: 2]))
                    T_INT: begin
                        if (n_int < 32'(cnt_int_q)) begin
                            disp_mask[i] = 1'b1;
                            n_int++;
                        end else begin
                            blocked = 1'b1;
                        end
                    end
                    T_MEM: begin
                        if (n_mem < 32'(cnt_mem_q)) begin
                            disp_mask[i] = 1'b1;
                            n_mem++;
                        end else begin
                            blocked = 1'b1;
                        end
                    end
                    T_FP: begin
                        if (n_fp < 32'(cnt_fp_q)) begin
                            disp_mask[i] = 1'b1;
                            n_fp++;
                        end else begin
                            blocked = 1'b1;
                        end
                    end
                    default: disp_mask[i] = 1'b1;
                endcase
            end
        end
        in_ready = in_valid && !blocked && !reset && !flush;
        if (reset || flush) begin
            disp_mask = '0;
        end
    end

    // Next-state for credits, done mask, sticky error and stall counter.
    always_comb begin
        nx_int    = int'(cnt_int_q) - int'(n_int) + int'(int_free);
        nx_mem    = int'(cnt_mem_q) - int'(n_mem) + int'(mem_free);
        nx_fp     = int'(cnt_fp_q)  - int'(n_fp)  + int'(fp_free);
        cnt_int_d = CIW'(sat(nx_int, IQ_INT_SIZE));
        cnt_mem_d = CMW'(sat(nx_mem, IQ_MEM_SIZE));
        cnt_fp_d  = CFW'(sat(nx_fp,  IQ_FP_SIZE));
        err_d     = err_q
                  | (nx_int > IQ_INT_SIZE) | (nx_int < 0)
                  | (nx_mem > IQ_MEM_SIZE) | (nx_mem < 0)
                  | (nx_fp  > IQ_FP_SIZE)  | (nx_fp  < 0);
        done_d    = in_ready ? '0 : (done_q | disp_mask);
        stall_d   = stall_q;
        if (in_valid && !in_ready && !flush && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
        // Flush discards this cycle's returns entirely, so no error can arise.
        if (flush) begin
            cnt_int_d = CIW'(IQ_INT_SIZE);
            cnt_mem_d = CMW'(IQ_MEM_SIZE);
            cnt_fp_d  = CFW'(IQ_FP_SIZE);
            err_d     = err_q;
            done_d    = '0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_int_q <= CIW'(IQ_INT_SIZE);
            cnt_mem_q <= CMW'(IQ_MEM_SIZE);
            cnt_fp_q  <= CFW'(IQ_FP_SIZE);
            done_q    <= '0;
            err_q     <= 1'b0;
            stall_q   <= '0;
        end else begin
            cnt_int_q <= cnt_int_d;
            cnt_mem_q <= cnt_mem_d;
            cnt_fp_q  <= cnt_fp_d;
            done_q    <= done_d;
            err_q     <= err_d;
            stall_q   <= stall_d;
        end
    end

    assign credit_err   = err_q;
    assign stall_cycles = stall_q;

endmodule
